// File: rtl/fifo_seq_pkg.sv
// Shared types and constants for the FIFO handshake sequencer.
package fifo_seq_pkg;

    // Sequencer states: one read path, one write path, shared idle.
    typedef enum logic [2:0] {
        StIdle,
        StRdPulse,
        StRdRecover,
        StWrSetup,
        StWrPulse,
        StWrHold
    } seq_state_e;

    // Arbitration history: which direction owned the bus last.
    localparam logic ARB_RX = 1'b0;
    localparam logic ARB_TX = 1'b1;

    // Reset values of the registered outputs and data holding registers.
    localparam logic RST_FIFO_RD     = 1'b1;
    localparam logic RST_FIFO_WR     = 1'b0;
    localparam logic RST_FIFO_OE     = 1'b0;
    localparam logic RST_KBD_STROBE  = 1'b0;
    localparam logic RST_DSP_READY   = 1'b1;
    localparam logic RST_DATA_BIT    = 1'b0;
    localparam logic RST_EDGE_HIST   = 1'b1;
    localparam logic RST_LAST_SERVED = ARB_TX;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Width of the shared phase down-counter.
    function automatic int unsigned cnt_width(input int unsigned rd_pulse,
                                              input int unsigned rd_recover,
                                              input int unsigned wr_pulse);
        return $clog2(max3(rd_pulse, rd_recover, wr_pulse)) + 1;
    endfunction

endpackage

// File: rtl/fifo_seq_sync.sv
// Two-flop synchronizer with a configurable reset value per bit.
module fifo_seq_sync #(
    parameter int unsigned       Width    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    // Two-stage capture; reset is synchronous to match the rest of the bridge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/fifo_sequencer.sv
// Handshake sequencer between the PIA keyboard/display ports and an FT245-style
// USB FIFO. Arbitrates the shared FIFO data bus, times RD#/WR strobes from
// programmable cycle counts and buffers one character in each direction.
// Build option: define FIFO_SEQ_SYNC_EN to insert two-flop synchronizers on
// fifo_rxf, fifo_txe, kbd_ack and dsp_req (adds two cycles of input latency).
module fifo_sequencer
    import fifo_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 7,
    parameter int unsigned RD_PULSE   = 4,  // cycles fifo_rd held low, >= 1
    parameter int unsigned RD_RECOVER = 2,  // cycles fifo_rd held high after a read, >= 1
    parameter int unsigned WR_PULSE   = 4   // cycles fifo_wr held high, >= 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] kbd_data,
    output logic                  kbd_strobe,
    input  logic                  kbd_ack,
    input  logic [DATA_WIDTH-1:0] dsp_data,
    input  logic                  dsp_req,
    output logic                  dsp_ready,
    input  logic                  fifo_rxf,
    input  logic                  fifo_txe,
    output logic                  fifo_rd,
    output logic                  fifo_wr,
    input  logic [DATA_WIDTH-1:0] fifo_data_in,
    output logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_data_oe
);

    localparam int unsigned CntW = cnt_width(RD_PULSE, RD_RECOVER, WR_PULSE);

    localparam logic [CntW-1:0] RdPulseLoad   = CntW'(RD_PULSE - 1);
    localparam logic [CntW-1:0] RdRecoverLoad = CntW'(RD_RECOVER - 1);
    localparam logic [CntW-1:0] WrPulseLoad   = CntW'(WR_PULSE - 1);

    localparam logic [DATA_WIDTH-1:0] RstData = {DATA_WIDTH{RST_DATA_BIT}};

    // Decision-side views of the asynchronous-capable inputs.
    logic rxf_s;
    logic txe_s;
    logic ack_s;
    logic req_s;

`ifdef FIFO_SEQ_SYNC_EN
    logic [1:0] fifo_flags_s;
    logic [1:0] pia_lines_s;

    // FIFO flags are active low, so they idle (and reset) high.
    fifo_seq_sync #(
        .Width    (2),
        .ResetVal (2'b11)
    ) u_sync_flags (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     ({fifo_rxf, fifo_txe}),
        .q_o     (fifo_flags_s)
    );

    fifo_seq_sync #(
        .Width    (2),
        .ResetVal (2'b00)
    ) u_sync_lines (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     ({kbd_ack, dsp_req}),
        .q_o     (pia_lines_s)
    );

    assign rxf_s = fifo_flags_s[1];
    assign txe_s = fifo_flags_s[0];
    assign ack_s = pia_lines_s[1];
    assign req_s = pia_lines_s[0];
`else
    assign rxf_s = fifo_rxf;
    assign txe_s = fifo_txe;
    assign ack_s = kbd_ack;
    assign req_s = dsp_req;
`endif

    seq_state_e            state_q,      state_d;
    logic [CntW-1:0]       cnt_q,        cnt_d;
    logic                  last_q,       last_d;
    logic                  fifo_rd_q,    fifo_rd_d;
    logic                  fifo_wr_q,    fifo_wr_d;
    logic                  fifo_oe_q,    fifo_oe_d;
    logic [DATA_WIDTH-1:0] data_out_q,   data_out_d;
    logic [DATA_WIDTH-1:0] kbd_data_q,   kbd_data_d;
    logic                  kbd_strobe_q, kbd_strobe_d;
    logic                  dsp_ready_q,  dsp_ready_d;
    logic [DATA_WIDTH-1:0] tx_buf_q,     tx_buf_d;
    logic                  ack_hist_q,   ack_hist_d;
    logic                  req_hist_q,   req_hist_d;

    logic ack_rise;
    logic req_rise;
    logic rx_req;
    logic tx_req;
    logic grant_rx;

    // Next-state logic: consumer-side handshakes first, then the bus FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        fifo_rd_d    = fifo_rd_q;
        fifo_wr_d    = fifo_wr_q;
        fifo_oe_d    = fifo_oe_q;
        data_out_d   = data_out_q;
        kbd_data_d   = kbd_data_q;
        kbd_strobe_d = kbd_strobe_q;
        dsp_ready_d  = dsp_ready_q;
        tx_buf_d     = tx_buf_q;
        ack_hist_d   = ack_s;
        req_hist_d   = req_s;

        ack_rise = ack_s & ~ack_hist_q;
        req_rise = req_s & ~req_hist_q;

        // An ack edge with nothing pending is ignored.
        if (ack_rise && kbd_strobe_q) begin
            kbd_strobe_d = 1'b0;
        end
        // A request edge while the buffer is still full is dropped.
        if (req_rise && dsp_ready_q) begin
            tx_buf_d    = dsp_data;
            dsp_ready_d = 1'b0;
        end

        rx_req   = enable & ~rxf_s & ~kbd_strobe_q;
        tx_req   = enable & ~txe_s & ~dsp_ready_q;
        // On a tie, serve the direction that did not go last.
        grant_rx = rx_req & (~tx_req | (last_q == ARB_TX));

        unique case (state_q)
            StIdle: begin
                if (grant_rx) begin
                    state_d   = StRdPulse;
                    cnt_d     = RdPulseLoad;
                    fifo_rd_d = 1'b0;
                    last_d    = ARB_RX;
                end else if (tx_req) begin
                    state_d    = StWrSetup;
                    fifo_oe_d  = 1'b1;
                    fifo_wr_d  = 1'b0;
                    data_out_d = tx_buf_q;
                    last_d     = ARB_TX;
                end
            end
            StRdPulse: begin
                if (cnt_q == '0) begin
                    // Data is valid at the end of the low pulse.
                    kbd_data_d   = fifo_data_in;
                    kbd_strobe_d = 1'b1;
                    fifo_rd_d    = 1'b1;
                    cnt_d        = RdRecoverLoad;
                    state_d      = StRdRecover;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRdRecover: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrSetup: begin
                fifo_wr_d = 1'b1;
                cnt_d     = WrPulseLoad;
                state_d   = StWrPulse;
            end
            StWrPulse: begin
                if (cnt_q == '0) begin
                    // FIFO latches on this falling edge; keep driving the bus one more cycle.
                    fifo_wr_d = 1'b0;
                    state_d   = StWrHold;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrHold: begin
                fifo_oe_d   = 1'b0;
                dsp_ready_d = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d   = StIdle;
                fifo_rd_d = RST_FIFO_RD;
                fifo_wr_d = RST_FIFO_WR;
                fifo_oe_d = RST_FIFO_OE;
            end
        endcase
    end

    // State and registered-output update; reset aborts any cycle in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_q       <= RST_LAST_SERVED;
            fifo_rd_q    <= RST_FIFO_RD;
            fifo_wr_q    <= RST_FIFO_WR;
            fifo_oe_q    <= RST_FIFO_OE;
            data_out_q   <= RstData;
            kbd_data_q   <= RstData;
            kbd_strobe_q <= RST_KBD_STROBE;
            dsp_ready_q  <= RST_DSP_READY;
            tx_buf_q     <= RstData;
            ack_hist_q   <= RST_EDGE_HIST;
            req_hist_q   <= RST_EDGE_HIST;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            fifo_rd_q    <= fifo_rd_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_oe_q    <= fifo_oe_d;
            data_out_q   <= data_out_d;
            kbd_data_q   <= kbd_data_d;
            kbd_strobe_q <= kbd_strobe_d;
            dsp_ready_q  <= dsp_ready_d;
            tx_buf_q     <= tx_buf_d;
            ack_hist_q   <= ack_hist_d;
            req_hist_q   <= req_hist_d;
        end
    end

    assign kbd_data      = kbd_data_q;
    assign kbd_strobe    = kbd_strobe_q;
    assign dsp_ready     = dsp_ready_q;
    assign fifo_rd       = fifo_rd_q;
    assign fifo_wr       = fifo_wr_q;
    assign fifo_data_out = data_out_q;
    assign fifo_data_oe  = fifo_oe_q;

endmodule
